// File: rtl/imm_operand_encoder.sv
// -----------------------------------------------------------------------------
// imm_operand_encoder
//
// Purpose:
//   Iteratively encodes a 32-bit constant into the ARM data-processing
//   immediate form {rotate_imm[3:0], imm8[7:0]}, where the constant equals
//   imm8 rotated right by 2*rotate_imm. One rotation is tried per cycle.
//   The plain constant is searched first. If that fails and ALLOW_INVERT is
//   set, ~value is searched next, so the caller can substitute MOV->MVN or
//   AND->BIC. Within a pass the lowest rotate_imm wins, so the encoding
//   returned is unique.
//
// Ports:
//   clk           in   system clock, rising-edge active
//   rst           in   synchronous active-high reset; aborts a search silently
//   start         in   request, accepted only while idle
//   value         in   constant to encode, sampled on the accepting edge
//   busy          out  high while a search pass is running
//   done          out  one-cycle pulse when the result is valid
//   found         out  an encoding exists (held until the next accepted start)
//   inverted      out  the encoding is of ~value
//   shift_operand out  {rotate_imm, imm8}; 12'h000 when found=0
// -----------------------------------------------------------------------------
module imm_operand_encoder #(
    parameter int REGISTER_LEN = 32,
    parameter int ALLOW_INVERT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [REGISTER_LEN-1:0] value,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic                    inverted,
    output logic [11:0]             shift_operand
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SEARCH_PLAIN = 2'd1,
        SEARCH_INV   = 2'd2,
        REPORT       = 2'd3
    } state_t;

    localparam logic ALLOW_INV_C = (ALLOW_INVERT != 32'sd0);

    // Pure barrel rotate-left: the upper word of {x,x} shifted left by amt.
    function automatic logic [REGISTER_LEN-1:0] rotl(
        input logic [REGISTER_LEN-1:0] x,
        input logic [4:0]              amt
    );
        logic [2*REGISTER_LEN-1:0] dbl;
        dbl = {x, x} << amt;
        return dbl[2*REGISTER_LEN-1 -: REGISTER_LEN];
    endfunction

    state_t                  state_r, state_s;
    logic [REGISTER_LEN-1:0] cand_r, cand_s;
    logic [3:0]              rot_r, rot_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    found_r, found_s;
    logic                    inv_r, inv_s;
    logic [11:0]             so_r, so_s;
    logic [REGISTER_LEN-1:0] probe_s;
    logic                    hit_s;

    // Candidate test: rotating left by 2*rot undoes a right rotation by the
    // same amount, so a hit leaves the whole constant in the low byte.
    always_comb begin
        probe_s = rotl(cand_r, {rot_r, 1'b0});
        hit_s   = (probe_s[REGISTER_LEN-1:8] == {(REGISTER_LEN-8){1'b0}});
    end

    // Next-state and next-output logic for the search controller.
    always_comb begin
        state_s = state_r;
        cand_s  = cand_r;
        rot_s   = rot_r;
        found_s = found_r;
        inv_s   = inv_r;
        so_s    = so_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    cand_s  = value;
                    rot_s   = 4'd0;
                    found_s = 1'b0;
                    inv_s   = 1'b0;
                    so_s    = 12'h000;
                    busy_s  = 1'b1;
                    state_s = SEARCH_PLAIN;
                end else begin
                    state_s = IDLE;
                end
            end
            SEARCH_PLAIN, SEARCH_INV: begin
                if (hit_s) begin
                    found_s = 1'b1;
                    inv_s   = (state_r == SEARCH_INV);
                    so_s    = {rot_r, probe_s[7:0]};
                    done_s  = 1'b1;
                    state_s = REPORT;
                end else if (rot_r != 4'd15) begin
                    rot_s   = rot_r + 4'd1;
                    busy_s  = 1'b1;
                end else if ((state_r == SEARCH_PLAIN) && ALLOW_INV_C) begin
                    // Plain pass exhausted: retry with the complemented constant.
                    cand_s  = ~cand_r;
                    rot_s   = 4'd0;
                    busy_s  = 1'b1;
                    state_s = SEARCH_INV;
                end else begin
                    found_s = 1'b0;
                    inv_s   = 1'b0;
                    so_s    = 12'h000;
                    done_s  = 1'b1;
                    state_s = REPORT;
                end
            end
            REPORT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cand_r  <= {REGISTER_LEN{1'b0}};
            rot_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            found_r <= 1'b0;
            inv_r   <= 1'b0;
            so_r    <= 12'h000;
        end else begin
            state_r <= state_s;
            cand_r  <= cand_s;
            rot_r   <= rot_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            found_r <= found_s;
            inv_r   <= inv_s;
            so_r    <= so_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign found         = found_r;
    assign inverted      = inv_r;
    assign shift_operand = so_r;

endmodule
